pipe_seg_buf: RTL and testbench

PIPE_SEG_BUF -- requirements
Module: pipe_seg_buf

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/seg_slot.sv | 34 +++
 rtl/pipe_seg_buf.sv | 151 +++++++++++++++
 tb/tb_pipe_seg_buf.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline segment buffer.
//   seg_state_t : FSM state encoding (EMPTY/BUSY/FULL, 2 bits)
//   OCC_*       : occupancy encoding reported on the occupancy port
//   occ_of()    : maps an FSM state to its occupancy value
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } seg_state_t;

  localparam logic [1:0] OCC_NONE = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  function automatic logic [1:0] occ_of(input seg_state_t s);
    case (s)
      ST_BUSY: return OCC_ONE;
      ST_FULL: return OCC_TWO;
      default: return OCC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/seg_slot.sv
// seg_slot: one payload register with a valid bit.
//   clk, rst_n : clock, async active-low reset (payload and valid cleared)
//   load       : capture d and mark the slot valid
//   clr        : synchronous clear of payload and valid; wins over load
//   d, q       : payload in / registered payload out (W bits)
//   vld        : slot holds an entry
// Clearing the payload (not just the valid bit) keeps an empty slot's
// control field at zero, which is what makes a bubble a NOP downstream.
module seg_slot #(
  parameter int W = 56
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_seg_buf.sv
// pipe_seg_buf: valid/ready pipeline segment with optional skid slot,
// synchronous flush and a saturating stall counter.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : upstream handshake
//   in_data/in_ctrl       : upstream payload (DATA_W / CTRL_W bits)
//   out_valid/out_ready   : downstream handshake
//   out_data/out_ctrl     : registered payload; out_ctrl is 0 when not valid
//   flush                 : kills all held entries at the next edge
//   occupancy             : entries held, 0..2
//   stall_cnt             : saturating count of out_valid && !out_ready cycles
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no entry held, out_valid = 0
// BUSY  | main slot holds the entry presented downstream
// FULL  | main and skid slots both hold entries (SKID=1)
module pipe_seg_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 24,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW      = DATA_W + CTRL_W;
  localparam bit SKID_EN = (SKID != 0);

  seg_state_t    state, state_nxt;
  logic          in_fire, out_fire;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic [PW-1:0] main_d, main_q, skid_q;
  logic          main_vld, skid_vld;

  assign out_valid = main_vld;
  assign out_data  = main_q[DATA_W-1:0];
  assign out_ctrl  = main_q[PW-1:DATA_W];
  assign occupancy = occ_of(state);

  // With the skid slot, ready comes from registered state only, which
  // breaks the out_ready -> in_ready timing path between stages.
  generate
    if (SKID_EN) begin : g_rdy_skid
      assign in_ready = (state != ST_FULL);
    end else begin : g_rdy_comb
      assign in_ready = !main_vld || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // When draining FULL the main slot refills from the skid slot; otherwise
  // it takes the upstream payload.
  assign main_d = skid_vld ? skid_q : {in_ctrl, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state_nxt = ST_BUSY;
        ST_BUSY: begin
          if (in_fire && !out_fire)      state_nxt = SKID_EN ? ST_FULL : ST_BUSY;
          else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_nxt = ST_BUSY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = in_fire;
        ST_BUSY: begin
          if (out_fire) begin
            main_load = in_fire;
            main_clr  = !in_fire;
          end else begin
            skid_load = in_fire && SKID_EN;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load = 1'b1;
            skid_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  seg_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_d),
    .q     (main_q),
    .vld   (main_vld)
  );

  seg_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clr   (skid_clr),
    .d     ({in_ctrl, in_data}),
    .q     (skid_q),
    .vld   (skid_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_seg_buf.sv
module tb_pipe_seg_buf;

  localparam int DW = 32;
  localparam int CW = 24;
  localparam int PW = DW + CW;

  logic clk, rst_n;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]    a_occ;
  logic [3:0]    a_stall;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [1:0]    b_occ;
  logic [15:0]   b_stall;

  int checks = 0;
  int errors = 0;

  // reference model: FIFO of {ctrl,data} plus a saturating stall count
  logic [PW-1:0] q0[$];
  int            cnt0;
  logic [PW-1:0] q1[$];

  pipe_seg_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .flush(a_flush), .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_seg_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .flush(b_flush), .occupancy(b_occ), .stall_cnt(b_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    a_in_valid = 0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 0; a_flush = 0;
    b_in_valid = 0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 0; b_flush = 0;
  endtask

  // One clock of stimulus on dut_a; the model advances at the same edge.
  task automatic cyc0(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic orr, input logic fl);
    bit m_ir, m_ov, in_f, out_f;
    a_in_valid = iv; a_in_data = d; a_in_ctrl = c; a_out_ready = orr; a_flush = fl;
    @(posedge clk);
    m_ir  = (q0.size() < 2);
    m_ov  = (q0.size() > 0);
    in_f  = iv && m_ir;
    out_f = m_ov && orr;
    if (m_ov && !orr && cnt0 < 15) cnt0++;
    if (fl) q0.delete();
    else begin
      if (out_f) void'(q0.pop_front());
      if (in_f)  q0.push_back({c, d});
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    idle_inputs();
    #2 rst_n = 0;
    q0.delete(); q1.delete(); cnt0 = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1;
    q0.delete(); q1.delete(); cnt0 = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", a_out_data); end
    checks++; if (a_out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=0", a_out_ctrl); end
    checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
    checks++; if (a_stall !== 4'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", a_stall); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_skid0 got=%0b exp=1", b_in_ready); end
    repeat (2) @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_hold_in_ready got=%0b exp=1", a_in_ready); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0b exp=1", a_in_ready); end
  endtask

  task automatic test_latency();
    cyc0(1, 32'h0000_1000, 24'h000abc, 1, 0);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL lat_out_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_data !== 32'h0000_1000) begin errors++; $display("FAIL lat_out_data got=%h exp=00001000", a_out_data); end
    checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL lat_occ got=%0d exp=1", a_occ); end
    cyc0(0, '0, '0, 1, 0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_ctrl !== '0) begin errors++; $display("FAIL lat_bubble_ctrl got=%h exp=0", a_out_ctrl); end
  endtask

  task automatic test_order();
    cyc0(1, 32'hA, 24'h11, 0, 0);
    cyc0(1, 32'hB, 24'h22, 0, 0);
    checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL order_occ_full got=%0d exp=2", a_occ); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL order_in_ready got=%0b exp=0", a_in_ready); end
    cyc0(1, 32'hE, 24'h33, 0, 0);
    checks++; if (a_out_data !== 32'hA) begin errors++; $display("FAIL order_hold_data got=%h exp=a", a_out_data); end
    checks++; if (a_out_ctrl !== 24'h11) begin errors++; $display("FAIL order_hold_ctrl got=%h exp=11", a_out_ctrl); end
    checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL order_hold_occ got=%0d exp=2", a_occ); end
    cyc0(0, '0, '0, 1, 0);
    checks++; if (a_out_data !== 32'hB) begin errors++; $display("FAIL order_second got=%h exp=b", a_out_data); end
    checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL order_occ_busy got=%0d exp=1", a_occ); end
    cyc0(0, '0, '0, 1, 0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got=%0b exp=0", a_out_valid); end
  endtask

  task automatic test_flush();
    cyc0(1, 32'hA1, 24'h5, 0, 0);
    cyc0(1, 32'hA2, 24'h6, 0, 0);
    cyc0(1, 32'hC, 24'h7, 0, 1);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_ctrl !== '0) begin errors++; $display("FAIL flush_out_ctrl got=%h exp=0", a_out_ctrl); end
    checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", a_occ); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", a_in_ready); end
    cyc0(0, '0, '0, 1, 0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_lost_entry got=%0b exp=0", a_out_valid); end
    cyc0(1, 32'hB1, 24'h8, 1, 0);
    cyc0(1, 32'hB2, 24'h9, 1, 1);
    checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush_prio_occ got=%0d exp=0", a_occ); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_prio_valid got=%0b exp=0", a_out_valid); end
  endtask

  task automatic test_stall_sat();
    pulse_reset();
    checks++; if (a_stall !== 4'd0) begin errors++; $display("FAIL stall_init got=%0d exp=0", a_stall); end
    cyc0(1, 32'h55, 24'h1, 0, 0);
    repeat (5) cyc0(0, '0, '0, 0, 0);
    checks++; if (a_stall !== 4'd5) begin errors++; $display("FAIL stall_count5 got=%0d exp=5", a_stall); end
    repeat (15) cyc0(0, '0, '0, 0, 0);
    checks++; if (a_stall !== 4'd15) begin errors++; $display("FAIL stall_sat got=%0d exp=15", a_stall); end
    checks++; if (a_out_data !== 32'h55) begin errors++; $display("FAIL stall_data_held got=%h exp=55", a_out_data); end
    repeat (3) cyc0(0, '0, '0, 0, 0);
    checks++; if (a_stall !== 4'd15) begin errors++; $display("FAIL stall_no_wrap got=%0d exp=15", a_stall); end
    cyc0(0, '0, '0, 0, 1);
    checks++; if (a_stall !== 4'd15) begin errors++; $display("FAIL stall_flush_kept got=%0d exp=15", a_stall); end
  endtask

  task automatic test_async_reset();
    cyc0(1, 32'h61, 24'h3, 0, 0);
    cyc0(1, 32'h62, 24'h4, 0, 0);
    checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL areset_pre_full got=%0d exp=2", a_occ); end
    #2 rst_n = 0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_data !== '0) begin errors++; $display("FAIL areset_data got=%h exp=0", a_out_data); end
    checks++; if (a_out_ctrl !== '0) begin errors++; $display("FAIL areset_ctrl got=%h exp=0", a_out_ctrl); end
    checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL areset_occ got=%0d exp=0", a_occ); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if (a_stall !== 4'd0) begin errors++; $display("FAIL areset_stall got=%0d exp=0", a_stall); end
    q0.delete(); cnt0 = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    cyc0(1, 32'h77, 24'hab, 1, 0);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL areset_restart_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_data !== 32'h77) begin errors++; $display("FAIL areset_restart_data got=%h exp=77", a_out_data); end
    checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL areset_restart_occ got=%0d exp=1", a_occ); end
    cyc0(0, '0, '0, 1, 0);
  endtask

  task automatic test_random();
    logic [DW-1:0] rd;
    logic [CW-1:0] rc;
    logic [PW-1:0] hd;
    bit iv, orr, fl;
    for (int i = 0; i < 400; i++) begin
      rd  = $urandom;
      rc  = CW'($urandom);
      iv  = ($urandom_range(0, 3) != 0);
      orr = (i < 200) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      cyc0(iv, rd, rc, orr, fl);
      hd = (q0.size() > 0) ? q0[0] : '0;
      checks++; if (a_out_valid !== (q0.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, a_out_valid, q0.size() > 0); end
      checks++; if (a_out_ctrl !== hd[PW-1:DW]) begin errors++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", i, a_out_ctrl, hd[PW-1:DW]); end
      if (q0.size() > 0) begin
        checks++; if (a_out_data !== hd[DW-1:0]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, a_out_data, hd[DW-1:0]); end
      end
      checks++; if (a_occ !== 2'(q0.size())) begin errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", i, a_occ, q0.size()); end
      checks++; if (a_in_ready !== (q0.size() < 2)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", i, a_in_ready, q0.size() < 2); end
      checks++; if (a_stall !== 4'(cnt0)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, a_stall, cnt0); end
    end
    cyc0(0, '0, '0, 0, 1);
  endtask

  task automatic test_skid0();
    int  sent = 0;
    int  dut_recv = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    bit  exp_ir;
    logic [PW-1:0] hd;
    while (dut_recv < 100 && cyc < 1000) begin
      b_in_valid  = (sent < 100);
      b_in_data   = DW'(sent);
      b_in_ctrl   = CW'(sent + 1);
      b_out_ready = tog;
      b_flush     = 0;
      #1;
      exp_ir = (q1.size() == 0) || tog;
      hd     = (q1.size() > 0) ? q1[0] : '0;
      checks++; if (b_in_ready !== exp_ir) begin errors++; $display("FAIL skid0_in_ready cyc=%0d got=%0b exp=%0b", cyc, b_in_ready, exp_ir); end
      checks++; if (b_out_valid !== (q1.size() > 0)) begin errors++; $display("FAIL skid0_valid cyc=%0d got=%0b exp=%0b", cyc, b_out_valid, q1.size() > 0); end
      checks++; if (b_occ !== 2'(q1.size())) begin errors++; $display("FAIL skid0_occ cyc=%0d got=%0d exp=%0d", cyc, b_occ, q1.size()); end
      checks++; if (b_out_ctrl !== hd[PW-1:DW]) begin errors++; $display("FAIL skid0_ctrl cyc=%0d got=%h exp=%h", cyc, b_out_ctrl, hd[PW-1:DW]); end
      if (b_out_valid === 1'b1 && tog) begin
        checks++; if (b_out_data !== DW'(dut_recv)) begin errors++; $display("FAIL skid0_seq cyc=%0d got=%0d exp=%0d", cyc, b_out_data, dut_recv); end
        dut_recv++;
      end
      @(posedge clk);
      if (q1.size() > 0 && tog) void'(q1.pop_front());
      if (b_in_valid && exp_ir) begin
        q1.push_back({b_in_ctrl, b_in_data});
        sent++;
      end
      tog = !tog;
      cyc++;
      @(negedge clk);
    end
    b_in_valid = 0; b_out_ready = 0;
    checks++; if (dut_recv != 100) begin errors++; $display("FAIL skid0_count got=%0d exp=100 (cycle budget)", dut_recv); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    test_reset();
    test_latency();
    test_order();
    test_flush();
    test_stall_sat();
    test_async_reset();
    test_random();
    test_skid0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
